// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding, IF/ID payload, bubble encoding, opcodes.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      KILL  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pcplus4;
      logic [31:0] instr;
   } ifid_t;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register {valid, pcplus4, instr}; flush has priority over enable.
module ifid_reg import mips_pkg::*; #(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  en,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   localparam ifid_t BUBBLE = '{valid: 1'b0, pcplus4: 32'h0, instr: NOP_INSTR};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      q <= BUBBLE;
      else if (flush) q <= BUBBLE;
      else if (en)    q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, single-outstanding imem request FSM, hold buffer and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to keep the instruction after a branch instead of flushing it.
module fetch_stage import mips_pkg::*; #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pcplus4_d,
   output logic        valid_d
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   fetch_state_t state, state_nx;
   logic [31:0]  pc_f, pc_nx, hold_buf, buf_nx, tgt, tgt_nx;
   logic [31:0]  pcplus4_f, redir_tgt;
   logic         ds_pend, pend_nx;
   logic         ifid_en, ifid_flush;
   ifid_t        ifid_d, ifid_q;

   assign pcplus4_f = pc_f + 32'd4;
   assign redir_tgt = word_align(redirect_pc);
   assign imem_req  = !reset && (state != HOLD);
   assign imem_addr = pc_f;

   always_comb begin
      state_nx   = state;
      pc_nx      = pc_f;
      buf_nx     = hold_buf;
      tgt_nx     = tgt;
      pend_nx    = ds_pend;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      ifid_d     = '{valid: 1'b1, pcplus4: pcplus4_f, instr: imem_rdata};
      unique case (state)
         FETCH: begin
            if (redirect) begin
               if (imem_ready) begin
                  pc_nx      = redir_tgt;
                  ifid_en    = DELAY_SLOT;
                  ifid_flush = !DELAY_SLOT;
               end else begin
                  // request in flight: address must stay put until the memory answers
                  ifid_flush = 1'b1;
                  tgt_nx     = redir_tgt;
                  pend_nx    = DELAY_SLOT;
                  state_nx   = KILL;
               end
            end else if (imem_ready) begin
               if (stall) begin
                  buf_nx   = imem_rdata;
                  state_nx = HOLD;
               end else begin
                  ifid_en = 1'b1;
                  pc_nx   = pcplus4_f;
               end
            end
         end
         HOLD: begin
            ifid_d.instr = hold_buf;
            if (redirect) begin
               pc_nx      = redir_tgt;
               pend_nx    = 1'b0;
               ifid_en    = DELAY_SLOT;
               ifid_flush = !DELAY_SLOT;
               state_nx   = FETCH;
            end else if (!stall) begin
               ifid_en  = 1'b1;
               pc_nx    = ds_pend ? tgt : pcplus4_f;
               pend_nx  = 1'b0;
               state_nx = FETCH;
            end
         end
         KILL: begin
            if (redirect) tgt_nx = redir_tgt;
            ifid_flush = redirect;
            if (imem_ready) begin
               pc_nx    = redirect ? redir_tgt : tgt;
               pend_nx  = 1'b0;
               state_nx = FETCH;
               if (ds_pend) begin
                  // delay-slot fetch completing: keep it, then continue at the target
                  if (stall && !redirect) begin
                     buf_nx   = imem_rdata;
                     pc_nx    = pc_f;
                     pend_nx  = 1'b1;
                     state_nx = HOLD;
                  end else begin
                     ifid_en    = 1'b1;
                     ifid_flush = 1'b0;
                  end
               end
            end
         end
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         pc_f     <= RESET_PC;
         hold_buf <= NOP_INSTR;
         tgt      <= RESET_PC;
         ds_pend  <= 1'b0;
      end else begin
         state    <= state_nx;
         pc_f     <= pc_nx;
         hold_buf <= buf_nx;
         tgt      <= tgt_nx;
         ds_pend  <= pend_nx;
      end
   end

   ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
      .clk   (clk),
      .reset (reset),
      .en    (ifid_en),
      .flush (ifid_flush),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign instr_d   = ifid_q.instr;
   assign pcplus4_d = ifid_q.pcplus4;
   assign valid_d   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency imem model, IF/ID scoreboard and directed checks.
module tb_fetch_stage;
   import mips_pkg::*;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_ready, valid_d;
   logic [31:0] imem_addr, imem_rdata, instr_d, pcplus4_d;
   logic        req2, ready2, valid2;
   logic [31:0] addr2, rdata2, instr2, pc4_2;
   int          lat = 1;
   int          cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [64:0] sbq[$];
   logic [64:0] prev;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_0005;
      if (a == 32'h4) return 32'h2009_000A;
      return {16'h2400, a[15:0]};
   endfunction

   function automatic logic [64:0] ent(input logic [31:0] i, input logic [31:0] p, input logic v);
      return {v, p, i};
   endfunction

   // memory answers in the lat-th cycle of a request
   assign imem_ready = imem_req && (cnt >= lat - 1);
   assign imem_rdata = mem(imem_addr);
   always @(posedge clk) cnt <= (imem_req && !imem_ready) ? cnt + 1 : 0;

   assign ready2 = req2;
   assign rdata2 = mem(addr2);

   fetch_stage u_dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2), .imem_rdata(rdata2),
      .instr_d(instr2), .pcplus4_d(pc4_2), .valid_d(valid2)
   );

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [64:0] ifid();
      return ent(instr_d, pcplus4_d, valid_d);
   endfunction

   // every new IF/ID content must match the next expected entry
   always @(negedge clk) begin
      logic [64:0] cur;
      cur = ifid();
      if (!reset && cur !== prev) begin
         if (sbq.size() == 0) chk("sb_unexpected", cur, prev);
         else                 chk("sb_ifid", cur, sbq.pop_front());
      end
      prev = cur;
   end

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      prev = ent(32'h0, 32'h0, 1'b0);
      tick(); tick();
      chk("rst_req", imem_req, 1'b0);
      chk("rst_ifid", ifid(), ent(32'h0, 32'h0, 1'b0));
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);

      // 1: back-to-back single-cycle fetches
      reset = 1'b0;
      sbq.push_back(ent(32'h2008_0005, 32'h4, 1'b1));
      sbq.push_back(ent(32'h2009_000A, 32'h8, 1'b1));
      #1;
      chk("t1_req", imem_req, 1'b1);
      chk("t1_lat", valid_d, 1'b0);
      tick();
      chk("t1_i0", ifid(), ent(32'h2008_0005, 32'h4, 1'b1));
      chk("t1_addr", imem_addr, 32'h4);
      chk("t5_wrap_ifid", ent(instr2, pc4_2, valid2), ent(32'h2400_FFFC, 32'h0, 1'b1));
      chk("t5_wrap_addr", addr2, 32'h0);
      tick();
      chk("t1_i1", ifid(), ent(32'h2009_000A, 32'h8, 1'b1));

      // 2: stall while memory is ready
      stall = 1'b1;
      repeat (3) begin
         tick();
         chk("t2_req", imem_req, 1'b0);
         chk("t2_hold", ifid(), ent(32'h2009_000A, 32'h8, 1'b1));
      end
      stall = 1'b0;
      sbq.push_back(ent(32'h2400_0008, 32'hC, 1'b1));
      sbq.push_back(ent(32'h2400_000C, 32'h10, 1'b1));
      tick();
      chk("t2_release", ifid(), ent(32'h2400_0008, 32'hC, 1'b1));
      chk("t2_addr", imem_addr, 32'hC);
      tick();
      chk("t2_next", ifid(), ent(32'h2400_000C, 32'h10, 1'b1));

      // 3: redirect while a 3-cycle fetch of 0x10 is in flight
      lat = 3; redirect = 1'b1; redirect_pc = 32'h40;
      sbq.push_back(ent(32'h0, 32'h0, 1'b0));
      if (DS) sbq.push_back(ent(32'h2400_0010, 32'h14, 1'b1));
      tick();
      redirect = 1'b0;
      chk("t3_flush", valid_d, 1'b0);
      chk("t3_addr_held", imem_addr, 32'h10);
      chk("t3_req", imem_req, 1'b1);
      tick();
      chk("t3_addr_held2", imem_addr, 32'h10);
      tick();
      chk("t3_target", imem_addr, 32'h40);
      chk("t3_discard", valid_d, DS);
      sbq.push_back(ent(32'h2400_0040, 32'h44, 1'b1));
      tick(); tick();
      chk("t3_slow_lat", valid_d, DS);
      tick();
      chk("t3_fetch", ifid(), ent(32'h2400_0040, 32'h44, 1'b1));

      // 4: redirect with stall, unaligned target
      lat = 1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h103;
      sbq.push_back(DS ? ent(32'h2400_0044, 32'h48, 1'b1) : ent(32'h0, 32'h0, 1'b0));
      tick();
      redirect = 1'b0; stall = 1'b0;
      chk("t4_flush", ifid(), DS ? ent(32'h2400_0044, 32'h48, 1'b1) : ent(32'h0, 32'h0, 1'b0));
      chk("t4_addr", imem_addr, 32'h100);
      chk("t4_no_hold", imem_req, 1'b1);
      sbq.push_back(ent(32'h2400_0100, 32'h104, 1'b1));
      tick();
      chk("t4_fetch", ifid(), ent(32'h2400_0100, 32'h104, 1'b1));

      // asynchronous reset in the middle of a slow fetch
      lat = 3;
      tick();
      reset = 1'b1;
      #1;
      chk("t7_req_drop", imem_req, 1'b0);
      chk("t7_ifid", ifid(), ent(32'h0, 32'h0, 1'b0));
      chk("t7_pc", imem_addr, 32'h0);
      tick();
      reset = 1'b0; lat = 1;
      sbq.push_back(ent(32'h2008_0005, 32'h4, 1'b1));
      tick();
      chk("t7_restart", ifid(), ent(32'h2008_0005, 32'h4, 1'b1));

`ifdef BRANCH_DELAY_SLOT_EN
      // 6: delay slot kept on redirect from branch @0x10
      for (int a = 4; a <= 16; a += 4) begin
         sbq.push_back(ent(mem(32'(a)), 32'(a + 4), 1'b1));
         tick();
      end
      chk("t6_branch", ifid(), ent(32'h2400_0010, 32'h14, 1'b1));
      redirect = 1'b1; redirect_pc = 32'h80;
      sbq.push_back(ent(32'h2400_0014, 32'h18, 1'b1));
      tick();
      redirect = 1'b0; lat = 3;
      chk("t6_slot", ifid(), ent(32'h2400_0014, 32'h18, 1'b1));
      chk("t6_target", imem_addr, 32'h80);
      redirect = 1'b1; redirect_pc = 32'hC0;
      sbq.push_back(ent(32'h0, 32'h0, 1'b0));
      sbq.push_back(ent(32'h2400_0080, 32'h84, 1'b1));
      tick();
      redirect = 1'b0;
      chk("t6_inflight_addr", imem_addr, 32'h80);
      tick(); tick();
      chk("t6_slot_done", ifid(), ent(32'h2400_0080, 32'h84, 1'b1));
      chk("t6_target2", imem_addr, 32'hC0);
      redirect = 1'b1; redirect_pc = 32'h200;
      sbq.push_back(ent(32'h0, 32'h0, 1'b0));
      tick();
      redirect = 1'b0;
      chk("t6_kill_addr", imem_addr, 32'hC0);
      reset = 1'b1;
      #1;
      chk("t6_rst_req", imem_req, 1'b0);
      chk("t6_rst_pc", imem_addr, 32'h0);
      tick();
      reset = 1'b0; lat = 1;
      sbq.push_back(ent(32'h2008_0005, 32'h4, 1'b1));
      tick();
      chk("t6_restart", ifid(), ent(32'h2008_0005, 32'h4, 1'b1));
`endif

      tick();
      chk("sb_drain", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
